// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit feeder: default geometry,
// acknowledge window length and the issue FSM state encoding.
package uart_pkg;

  localparam int DEPTH_DEF   = 8;
  localparam int WIDTH_DEF   = 8;
  // Cycles the feeder waits in S_ACK for core_busy before assuming the
  // core took (or ignored) the request.
  localparam int ACK_TIMEOUT = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_WAIT = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Host/core-facing signal bundle of uart_tx_feeder.
//   master : host and UART core side (drives writes, controls, core_busy)
//   slave  : the feeder (drives tx_data/tx_req and the status outputs)
interface uart_tx_feeder_if
  import uart_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = $clog2(DEPTH_DEF) + 1
);
  logic [WIDTH-1:0] wr_data;
  logic             wr_en;
  logic             flush;
  logic             enable;
  logic             clr_ovf;
  logic             core_busy;
  logic [WIDTH-1:0] tx_data;
  logic             tx_req;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             idle;

  modport master (
    output wr_data, wr_en, flush, enable, clr_ovf, core_busy,
    input  tx_data, tx_req, full, empty, count, overflow, idle
  );

  modport slave (
    input  wr_data, wr_en, flush, enable, clr_ovf, core_busy,
    output tx_data, tx_req, full, empty, count, overflow, idle
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count.
//   clk, rst  : clock, synchronous active-high reset
//   i_push    : enqueue request (i_wdata)
//   i_pop     : dequeue request; o_rdata is the head before the edge
//   i_flush   : empty the FIFO, suppressing push/pop this cycle
//   o_full/o_empty/o_count : occupancy status
//   o_drop    : push refused because full with no same-cycle pop
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count,
  output logic             o_drop
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  // When full, the slot freed by a same-cycle pop is the one written, since
  // wr_ptr == rd_ptr and the head is read out before the edge.
  assign w_pop  = i_pop && !o_empty && !i_flush;
  assign w_push = i_push && (!o_full || w_pop) && !i_flush;
  assign o_drop = i_push && o_full && !w_pop && !i_flush;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_feeder.sv
// Transmit buffer and issue stage ahead of the UART core transmitter.
// Bytes are queued in sync_fifo and handed to the core one at a time with
// a one-cycle tx_req pulse, waiting out each frame via core_busy.
//   clk, rst : clock, synchronous active-high reset
//   bus      : uart_tx_feeder_if.slave (host writes/controls, core
//              handshake, status: full/empty/count/overflow/idle)
//
// state  | meaning
// S_IDLE | ready; issues head byte when enabled, queued and core idle
// S_ACK  | request sent; up to ACK_TIMEOUT cycles for core_busy to rise
// S_WAIT | core is sending the frame; wait for core_busy to fall
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_feeder_if.slave bus
);
  tx_state_t        r_state;
  tx_state_t        w_state_nxt;
  logic [1:0]       r_ack_cnt;
  logic [1:0]       w_ack_cnt_nxt;
  logic             w_issue;
  logic [WIDTH-1:0] r_tx_data;
  logic             r_tx_req;
  logic             r_overflow;
  logic [WIDTH-1:0] w_head;
  logic             w_empty;
  logic             w_full;
  logic [CW-1:0]    w_count;
  logic             w_drop;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CW(CW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.wr_en),
    .i_pop   (w_issue),
    .i_flush (bus.flush),
    .i_wdata (bus.wr_data),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_drop  (w_drop)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_ack_cnt_nxt = r_ack_cnt;
    w_issue       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.enable && !w_empty && !bus.core_busy && !bus.flush) begin
          w_issue       = 1'b1;
          w_state_nxt   = S_ACK;
          w_ack_cnt_nxt = 2'(ACK_TIMEOUT - 1);
        end
      end
      S_ACK: begin
        if (bus.core_busy)          w_state_nxt   = S_WAIT;
        else if (r_ack_cnt == 2'd0) w_state_nxt   = S_IDLE;
        else                        w_ack_cnt_nxt = r_ack_cnt - 1'b1;
      end
      S_WAIT: begin
        if (!bus.core_busy) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ack_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ack_cnt <= w_ack_cnt_nxt;
    end
  end

  // tx_data holds the last issued byte until the next issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_req  <= 1'b0;
      r_tx_data <= '0;
    end else begin
      r_tx_req <= w_issue;
      if (w_issue) r_tx_data <= w_head;
    end
  end

  // A drop in the same cycle as clr_ovf keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst)              r_overflow <= 1'b0;
    else if (w_drop)      r_overflow <= 1'b1;
    else if (bus.clr_ovf) r_overflow <= 1'b0;
  end

  assign bus.tx_data  = r_tx_data;
  assign bus.tx_req   = r_tx_req;
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.count    = w_count;
  assign bus.overflow = r_overflow;
  assign bus.idle     = w_empty && (r_state == S_IDLE) && !bus.core_busy;
endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;
  import uart_pkg::*;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_feeder_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  uart_tx_feeder #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: byte queue, sticky flag, and "frame in flight" tracking
  // expressed as remaining acknowledge window / waiting-for-busy-drop.
  logic [7:0] q[$];
  bit         m_ovf;
  bit         m_req;
  logic [7:0] m_data;
  int         m_window;
  bit         m_waiting;

  task automatic model_edge();
    bit issue, busy, drop;
    busy = bus.core_busy;
    drop = 1'b0;
    if (rst) begin
      q.delete();
      m_ovf = 0; m_req = 0; m_data = '0; m_window = 0; m_waiting = 0;
      return;
    end
    issue = bus.enable && (q.size() > 0) && !busy && !bus.flush && (m_window == 0) && !m_waiting;
    if (issue) m_window = ACK_TIMEOUT;
    else if (m_window > 0) begin
      if (busy) begin m_window = 0; m_waiting = 1; end
      else m_window--;
    end else if (m_waiting && !busy) m_waiting = 0;
    m_req = issue;
    if (issue) m_data = q[0];
    if (bus.flush) q.delete();
    else begin
      if (issue) void'(q.pop_front());
      if (bus.wr_en) begin
        if (q.size() < DEPTH) q.push_back(bus.wr_data);
        else drop = 1'b1;
      end
    end
    if (drop) m_ovf = 1;
    else if (bus.clr_ovf) m_ovf = 0;
  endtask

  task automatic check_all();
    bit m_idle;
    m_idle = (q.size() == 0) && (m_window == 0) && !m_waiting && !bus.core_busy;
    check_val("tx_req",   bus.tx_req,   m_req);
    check_val("tx_data",  bus.tx_data,  m_data);
    check_val("count",    bus.count,    q.size());
    check_val("full",     bus.full,     q.size() == DEPTH);
    check_val("empty",    bus.empty,    q.size() == 0);
    check_val("overflow", bus.overflow, m_ovf);
    check_val("idle",     bus.idle,     m_idle);
  endtask

  // Core model: responsive mode raises busy the cycle after it sees tx_req,
  // for core_len cycles (sometimes ignoring the request); random mode toggles.
  bit core_random = 0;
  int core_len = 40;
  int ign_pct = 0;
  int core_cnt = 0;
  bit req_seen = 0;
  logic [7:0] pulses[$];

  task automatic core_update();
    if (core_random) begin
      if ($urandom_range(0, 3) == 0) bus.core_busy = ~bus.core_busy;
    end else begin
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) bus.core_busy = 1'b0;
      end
      if (req_seen && core_len > 0 && $urandom_range(0, 99) >= ign_pct) begin
        bus.core_busy = 1'b1;
        core_cnt = core_len;
      end
    end
    req_seen = bus.tx_req;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (bus.tx_req) pulses.push_back(bus.tx_data);
    core_update();
  endtask

  task automatic write_byte(input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_data = '0; bus.wr_en = 0; bus.flush = 0; bus.enable = 0;
    bus.clr_ovf = 0; bus.core_busy = 0;

    // reset then idle
    tick(); tick();
    check_val("rst_empty", bus.empty, 1);
    check_val("rst_count", bus.count, 0);
    check_val("rst_req",   bus.tx_req, 0);
    check_val("rst_ovf",   bus.overflow, 0);
    check_val("rst_idle",  bus.idle, 1);
    rst = 1'b0;
    bus.enable = 1'b1;
    tick();

    // single byte, long core frame
    pulses.delete();
    write_byte(8'hA5);
    check_val("single_req_n", bus.tx_req, 0);
    tick();
    check_val("single_req_n1", bus.tx_req, 1);
    check_val("single_data", bus.tx_data, 8'hA5);
    tick();
    check_val("single_req_n2", bus.tx_req, 0);
    repeat (50) tick();
    check_val("single_pulses", pulses.size(), 1);
    check_val("single_idle", bus.idle, 1);
    check_val("single_count", bus.count, 0);

    // burst of three
    core_len = 6;
    pulses.delete();
    write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
    repeat (40) tick();
    check_val("burst_pulses", pulses.size(), 3);
    if (pulses.size() == 3) begin
      check_val("burst_b0", pulses[0], 8'h11);
      check_val("burst_b1", pulses[1], 8'h22);
      check_val("burst_b2", pulses[2], 8'h33);
    end

    // overflow with enable low
    core_len = 4;
    bus.enable = 1'b0;
    for (int i = 0; i < 9; i++) begin
      write_byte(8'h40 + 8'(i));
      if (i == 7) check_val("ovf_full8", bus.full, 1);
    end
    check_val("ovf_count", bus.count, 8);
    check_val("ovf_flag", bus.overflow, 1);
    bus.clr_ovf = 1'b1; tick(); bus.clr_ovf = 1'b0;
    check_val("ovf_clr", bus.overflow, 0);

    // full with same-cycle pop
    pulses.delete();
    bus.enable = 1'b1;
    write_byte(8'h7E);
    check_val("fwp_req", bus.tx_req, 1);
    check_val("fwp_count", bus.count, 8);
    check_val("fwp_ovf", bus.overflow, 0);
    repeat (120) tick();
    check_val("fwp_pulses", pulses.size(), 9);
    if (pulses.size() == 9) begin
      check_val("fwp_first", pulses[0], 8'h40);
      check_val("fwp_last", pulses[8], 8'h7E);
    end

    // flush mid-frame
    core_len = 10;
    pulses.delete();
    for (int i = 0; i < 4; i++) write_byte(8'hC0 + 8'(i));
    repeat (2) tick();
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    check_val("flush_count", bus.count, 0);
    repeat (30) tick();
    check_val("flush_pulses", pulses.size(), 1);

    // reset while core busy
    pulses.delete();
    write_byte(8'hD1); write_byte(8'hD2);
    repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check_val("mrst_empty", bus.empty, 1);
    repeat (20) tick();
    check_val("mrst_pulses", pulses.size(), 1);
    write_byte(8'h5C);
    repeat (20) tick();
    check_val("mrst_pulses2", pulses.size(), 2);
    if (pulses.size() == 2) check_val("mrst_data", pulses[1], 8'h5C);

    // randomized traffic
    for (int blk = 0; blk < 6; blk++) begin
      core_random = (blk % 3 == 2);
      core_len = $urandom_range(0, 6);
      ign_pct = $urandom_range(0, 40);
      bus.core_busy = 1'b0; core_cnt = 0;
      for (int c = 0; c < 500; c++) begin
        bus.wr_en   = ($urandom_range(0, 1) == 1);
        bus.wr_data = 8'($urandom);
        bus.flush   = ($urandom_range(0, 39) == 0);
        bus.enable  = ($urandom_range(0, 7) != 0);
        bus.clr_ovf = ($urandom_range(0, 15) == 0);
        rst         = ($urandom_range(0, 299) == 0);
        tick();
      end
    end
    rst = 1'b0; bus.wr_en = 0; bus.flush = 0; bus.clr_ovf = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
Transmit-side buffer and issue stage that sits directly upstream of the UART core's transmitter. It accepts bytes from the host side into a small synchronous FIFO. It then hands them to the core one at a time using the core's tx_data/tx_req/tx_busy handshake. This removes the need for the host to poll TX_BUSY between bytes.

Parameters:
DEPTH, 8, FIFO entries; must be a power of two, minimum 2
WIDTH, 8, data width in bits; matches the core's tx_data width
CW, $clog2(DEPTH)+1, width of the occupancy count

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
wr_data  in  WIDTH  byte to enqueue
wr_en  in  1  enqueue strobe; one byte per cycle when high
flush  in  1  discard all queued bytes
enable  in  1  1 = allowed to start new frames; 0 = hold queue
clr_ovf  in  1  clears sticky overflow flag
core_busy  in  1  core's tx_busy
tx_data  out  WIDTH  byte presented to core; registered
tx_req  out  1  one-cycle start pulse to core; registered
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  CW  current occupancy, 0..DEPTH
overflow  out  1  sticky; a write was dropped
idle  out  1  FIFO empty, FSM in S_IDLE and core_busy low

Behaviour:
- Reset (rst=1 at edge): rd/wr pointers=0, count=0, tx_data=0, tx_req=0, overflow=0, FSM=S_IDLE. Outputs: full=0, empty=1, idle=1 (given core_busy=0). An in-flight core frame is not aborted; the FSM restarts in S_IDLE and waits for core_busy low before issuing.
- Write acceptance: a write is accepted if wr_en=1 and (count<DEPTH or a pop occurs in the same cycle). The byte is stored at wr_ptr, and wr_ptr wraps modulo DEPTH.
- Dropped write: if wr_en=1 while full with no same-cycle pop, the byte is discarded and overflow is set.
- Overflow flag: clr_ovf=1 clears it. If a drop and clr_ovf=1 coincide, set wins.
- Pop: occurs only on the FSM issue cycle. The head byte is loaded into tx_data and rd_ptr advances modulo DEPTH.
- count update: +1 on write only, -1 on pop only, unchanged on both or neither.
- Flush: flush=1 sets pointers and count to 0 and suppresses any write or pop that cycle. A dropped write under flush does not set overflow. Flush does not cancel a tx_req already on the output and does not change FSM state.
- FSM states:
  - S_IDLE: if enable && !empty && !core_busy && !flush, then tx_req<=1, tx_data<=head, pop, go to S_ACK.
  - S_ACK: tx_req<=0. If core_busy=1, go to S_WAIT. If 2 cycles pass with core_busy still low, return to S_IDLE; the core accepted or ignored the request and the byte is considered sent.
  - S_WAIT: stay while core_busy=1; go to S_IDLE when core_busy=0.
- tx_req is exactly one clock wide. tx_data is stable from the issue edge until the next issue.
- Latency, empty queue with core idle: the byte written at edge N is stored at N. tx_req is high after edge N+1 and low after edge N+2.
- Back-to-back issue: after core_busy falls, the next tx_req occurs at the earliest 1 clock later.
- enable=0: no new issue; writes still accepted; an in-progress frame completes.

Decomposition:
- uart_pkg holds:
  - FSM state encoding S_IDLE/S_ACK/S_WAIT (2-bit).
  - Default DEPTH and WIDTH.
  - ACK_TIMEOUT=2.
- Sub-module sync_fifo (DEPTH, WIDTH): storage, pointers, count, full/empty, push/pop/flush inputs, and the same-cycle push-on-full-with-pop rule.
- uart_tx_feeder instantiates sync_fifo and contains the FSM, the tx_data/tx_req registers and the overflow flag.

Test Plan:
- Reset then idle: rst high 2 cycles, core_busy=0 -> empty=1, count=0, tx_req=0, overflow=0, idle=1.
- Single byte: write 0xA5 at edge N, model core raises busy 1 cycle after tx_req for 40 cycles -> tx_req pulses once after edge N+1, tx_data=0xA5, count returns 0, idle=1 after busy falls.
- Burst of 3: write 0x11,0x22,0x33 on consecutive cycles -> exactly 3 tx_req pulses in order 0x11,0x22,0x33. Each pulse occurs only with core_busy=0, and no pulse occurs while busy.
- Overflow, DEPTH=8, enable=0: write 9 bytes -> full=1 after the 8th, 9th dropped, overflow=1, count=8. Pulse clr_ovf -> overflow=0. Set enable=1 -> 8 frames issued.
- Full with pop: full, enable=1, core idle, write 0x7E on the issue cycle -> write accepted, count stays 8, overflow=0.
- Flush and mid-frame reset: queue 4 bytes, assert flush while a frame is in progress -> count=0, current frame completes, no further tx_req. Queue 2 bytes, assert rst while core_busy=1 -> queue empty, no tx_req until core_busy low and a new write.
